// File: rtl/sc_io_ctrl.sv
// sc_io_ctrl: memory-mapped I/O controller with synchronised inputs, sticky change
// status and a maskable IRQ. Define IO_DEBOUNCE_EN to add per-port debounce filters.
module sc_io_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned N_IN        = 2,
  parameter int unsigned N_OUT       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [5:0]              io_addr,
  input  logic                    io_we,
  input  logic [WIDTH-1:0]        io_wdata,
  output logic [WIDTH-1:0]        io_rdata,
  input  logic [N_IN*WIDTH-1:0]   in_port,
  output logic [N_OUT*WIDTH-1:0]  out_port,
  output logic                    io_irq
);

  // IN doubles as the last synchroniser stage, so SYNC_STAGES-1 flops precede it.
  localparam int unsigned SW         = SYNC_STAGES - 1;
  localparam int unsigned IDX_IN     = 8;
  localparam int unsigned IDX_STATUS = 14;
  localparam int unsigned IDX_MASK   = 15;

  logic [31:0]       widx;
  logic [WIDTH-1:0]  sync_q [N_IN][SW];
  logic [WIDTH-1:0]  in_q   [N_IN];
  logic [WIDTH-1:0]  out_q  [N_OUT];
  logic [N_IN-1:0]   status_q;
  logic [N_IN-1:0]   mask_q;
  logic [N_IN-1:0]   in_load;
  logic [N_IN-1:0]   in_chg;
  logic [N_IN-1:0]   w1c;
  logic              unused_bits;

  assign widx        = 32'(io_addr[5:2]);
  assign unused_bits = ^io_addr[1:0];

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned    CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  DEB_MAX = CW'(DEB_CYCLES);

  logic [CW-1:0]    cnt_q    [N_IN];
  logic [CW-1:0]    cnt_d    [N_IN];
  logic [WIDTH-1:0] s_prev_q [N_IN];

  // Loading on the counter's next value keeps total latency at SYNC_STAGES+DEB_CYCLES.
  always_comb begin
    in_load = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i][SW-1] != s_prev_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DEB_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      in_load[i] = (cnt_d[i] == DEB_MAX);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt_q[i]    <= '0;
        s_prev_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        cnt_q[i]    <= cnt_d[i];
        s_prev_q[i] <= sync_q[i][SW-1];
      end
    end
  end
`else
  localparam int unsigned unused_deb = DEB_CYCLES;

  always_comb in_load = '1;
`endif

  always_comb begin
    w1c    = '0;
    in_chg = '0;
    if (io_we && widx == IDX_STATUS) w1c = io_wdata[N_IN-1:0];
    for (int unsigned i = 0; i < N_IN; i++) begin
      in_chg[i] = in_load[i] && (sync_q[i][SW-1] != in_q[i]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        for (int unsigned k = 0; k < SW; k++) sync_q[i][k] <= '0;
        in_q[i] <= '0;
      end
      for (int unsigned o = 0; o < N_OUT; o++) out_q[o] <= '0;
      status_q <= '0;
      mask_q   <= '0;
      io_irq   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        sync_q[i][0] <= in_port[i*WIDTH +: WIDTH];
        for (int unsigned k = 1; k < SW; k++) sync_q[i][k] <= sync_q[i][k-1];
        if (in_load[i]) in_q[i] <= sync_q[i][SW-1];
      end
      // A change on the same edge as a W1C keeps the bit set.
      status_q <= (status_q & ~w1c) | in_chg;
      io_irq   <= |(status_q & mask_q);
      if (io_we && widx == IDX_MASK) mask_q <= io_wdata[N_IN-1:0];
      for (int unsigned o = 0; o < N_OUT; o++) begin
        if (io_we && widx == o) out_q[o] <= io_wdata;
      end
    end
  end

  always_comb begin
    out_port = '0;
    for (int unsigned o = 0; o < N_OUT; o++) out_port[o*WIDTH +: WIDTH] = out_q[o];
  end

  always_comb begin
    io_rdata = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      if (widx == o) io_rdata = out_q[o];
    end
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (widx == IDX_IN + i) io_rdata = in_q[i];
    end
    if (widx == IDX_STATUS) io_rdata[N_IN-1:0] = status_q;
    if (widx == IDX_MASK)   io_rdata[N_IN-1:0] = mask_q;
  end

endmodule

// File: tb/tb_sc_io_ctrl.sv
// Randomised self-checking bench for sc_io_ctrl against a cycle-level reference model
// built from input history, latency rules and the register map.
module tb_sc_io_ctrl;

  localparam int WIDTH       = 32;
  localparam int N_IN        = 2;
  localparam int N_OUT       = 3;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
  // Input driven before edge j becomes visible in IN at edge j+LAG.
  localparam int LAG         = SYNC_STAGES - 1;
  localparam int HMAX        = 8192;

  logic                   clock = 1'b0;
  logic                   resetn;
  logic [5:0]             io_addr;
  logic                   io_we;
  logic [WIDTH-1:0]       io_wdata;
  logic [WIDTH-1:0]       io_rdata;
  logic [N_IN*WIDTH-1:0]  in_port;
  logic [N_OUT*WIDTH-1:0] out_port;
  logic                   io_irq;

  sc_io_ctrl #(
    .WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT),
    .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clock(clock), .resetn(resetn), .io_addr(io_addr), .io_we(io_we),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .in_port(in_port),
    .out_port(out_port), .io_irq(io_irq)
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] m_out [N_OUT];
  logic [WIDTH-1:0] m_in  [N_IN];
  logic [N_IN-1:0]  m_status, m_mask;
  logic             m_irq;
  int               k;
  logic [WIDTH-1:0] hist [N_IN][HMAX];

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < N_OUT; o++) m_out[o] = '0;
    for (int p = 0; p < N_IN; p++) m_in[p] = '0;
    m_status = '0;
    m_mask   = '0;
    m_irq    = 1'b0;
    k        = 0;
  endtask

  function automatic logic [WIDTH-1:0] hval(input int p, input int j);
    return (j < 1) ? '0 : hist[p][j];
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input int idx);
    logic [WIDTH-1:0] r;
    r = '0;
    if (idx < N_OUT) r = m_out[idx];
    else if (idx >= 8 && idx < 8 + N_IN) r = m_in[idx-8];
    else if (idx == 14) r[N_IN-1:0] = m_status;
    else if (idx == 15) r[N_IN-1:0] = m_mask;
    return r;
  endfunction

  task automatic model_edge();
    logic [N_IN-1:0]  chg, clr;
    logic [WIDTH-1:0] nv;
    int               idx;
    bit               stable;
    k++;
    for (int p = 0; p < N_IN; p++) hist[p][k] = in_port[p*WIDTH +: WIDTH];
    chg = '0;
    for (int p = 0; p < N_IN; p++) begin
      nv = m_in[p];
`ifdef IO_DEBOUNCE_EN
      stable = (k >= DEB_CYCLES);
      for (int j = k - LAG - DEB_CYCLES; j <= k - LAG; j++) begin
        if (hval(p, j) != hval(p, k - LAG)) stable = 1'b0;
      end
      if (stable) nv = hval(p, k - LAG);
`else
      stable = 1'b1;
      if (stable) nv = hval(p, k - LAG);
`endif
      chg[p] = (nv != m_in[p]);
      m_in[p] = nv;
    end
    idx = int'(io_addr[5:2]);
    m_irq = |(m_status & m_mask);
    clr = (io_we && idx == 14) ? io_wdata[N_IN-1:0] : '0;
    m_status = (m_status & ~clr) | chg;
    if (io_we) begin
      if (idx < N_OUT) m_out[idx] = io_wdata;
      if (idx == 15) m_mask = io_wdata[N_IN-1:0];
    end
  endtask

  task automatic cyc(input logic [N_IN*WIDTH-1:0] inp, input logic we, input int idx,
                     input logic [WIDTH-1:0] wd);
    @(negedge clock);
    in_port  = inp;
    io_we    = we;
    io_addr  = {4'(idx), 2'($urandom)};
    io_wdata = wd;
    #1 check($sformatf("load_idx%0d", idx), io_rdata, m_read(idx));
    @(posedge clock);
    model_edge();
    #1;
    for (int o = 0; o < N_OUT; o++) check($sformatf("out_port%0d", o), out_port[o*WIDTH +: WIDTH], m_out[o]);
    check("io_irq", io_irq, m_irq);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(in_port, 1'b0, $urandom_range(0, 15), '0);
  endtask

  task automatic peek(input string tag, input int idx, input logic [WIDTH-1:0] exp);
    io_we   = 1'b0;
    io_addr = {4'(idx), 2'b00};
    #1 check(tag, io_rdata, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_port"}, WIDTH'(|out_port), '0);
    check({tag, "_irq"}, io_irq, '0);
    for (int a = 0; a < 16; a++) peek($sformatf("%s_rd%0d", tag, a), a, '0);
  endtask

  logic [N_IN*WIDTH-1:0] nxt;

  initial begin
    resetn = 1'b0; in_port = '0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    model_reset();
    #1 check_all_zero("por");
    @(posedge clock); #1 resetn = 1'b1;
    idle(4);

    // Output path and unmapped store
    cyc(in_port, 1'b1, 2, 32'hDEADBEEF);
    check("out2_direct", out_port[95:64], 32'hDEADBEEF);
    peek("rd_out2", 2, 32'hDEADBEEF);
    cyc(in_port, 1'b1, 5, 32'h12345678);
    peek("rd_idx5", 5, '0);
    check("out2_kept", out_port[95:64], 32'hDEADBEEF);
    cyc(in_port, 1'b1, 2, 32'h0BADF00D);
    peek("rd_out2_new", 2, 32'h0BADF00D);

    // Input latency, STATUS set, IRQ one edge later
    cyc(in_port, 1'b1, 15, 32'h1);
    nxt = in_port; nxt[31:0] = 32'h55;
    cyc(nxt, 1'b0, 0, '0);
    repeat (SYNC_STAGES - 1) begin
      peek("in0_early", 8, '0);
      cyc(in_port, 1'b0, 0, '0);
    end
    peek("in0_at_sync", 8, 32'h55);
    peek("status_at_sync", 14, 32'h1);
    check("irq_not_yet", io_irq, '0);
    idle(1);
    check("irq_set", io_irq, 1'b1);

    // W1C against a simultaneous change
    cyc(in_port, 1'b1, 15, 32'h3);
    cyc(in_port, 1'b1, 14, 32'h3);
    nxt = in_port; nxt[63:32] = 32'hA5;
    cyc(nxt, 1'b0, 0, '0);
    idle(SYNC_STAGES);
    cyc(in_port, 1'b1, 14, 32'h3);
    peek("status_cleared", 14, '0);
    nxt = in_port; nxt[63:32] = 32'h5A;
    cyc(nxt, 1'b0, 0, '0);
    repeat (LAG - 1) cyc(in_port, 1'b0, 0, '0);
    cyc(in_port, 1'b1, 14, 32'h2);
    peek("w1c_conflict", 14, 32'h2);
    cyc(in_port, 1'b1, 14, 32'h2);
    peek("w1c_clear", 14, '0);
    check("irq_still_high", io_irq, 1'b1);
    idle(1);
    check("irq_fell", io_irq, '0);

    // Mid-run reset with pending IRQ
    cyc(in_port, 1'b1, 0, 32'h1234);
    nxt = in_port; nxt[31:0] = 32'h77;
    cyc(nxt, 1'b0, 0, '0);
    idle(SYNC_STAGES + 1);
    check("irq_before_reset", io_irq, 1'b1);
    check("out0_before_reset", out_port[31:0], 32'h1234);
    @(negedge clock); #2;
    resetn = 1'b0; in_port = '0;
    #1 check_all_zero("midrst");
    model_reset();
    @(posedge clock); #1 resetn = 1'b1;
    idle(SYNC_STAGES + DEB_CYCLES + 2);
    peek("status_after_rst", 14, '0);

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      nxt = in_port;
      for (int p = 0; p < N_IN; p++) begin
        if ($urandom_range(0, 3) == 0)
          nxt[p*WIDTH +: WIDTH] = $urandom_range(0, 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 2) == 0)
        cyc(nxt, 1'b1, $urandom_range(0, 15), WIDTH'($urandom));
      else
        cyc(nxt, 1'b0, $urandom_range(0, 15), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sc_io_ctrl.md
# sc_io_ctrl

Parametrised memory-mapped I/O controller for the single-cycle computer; replaces the fixed two-input/three-output port logic that was folded into the data memory. It sits beside the data memory on the CPU's load/store bus, adds input synchronisation, per-port change detection with a sticky status register, and a maskable interrupt request. Loads return data combinationally, as the single-cycle datapath requires. Stores take effect on the rising clock edge.

## Interface
- WIDTH, 32: data width of every port and register.
- N_IN, 2: number of input ports, 1..6.
- N_OUT, 3: number of output ports, 1..8.
- SYNC_STAGES, 2: synchroniser flops per input port, ≥2.
- DEB_CYCLES, 16: debounce stability count, ≥1; used only when IO_DEBOUNCE_EN is defined.

Ports:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- io_addr  in  6  byte address within the I/O window; [5:2] is the word index, [1:0] is ignored.
- io_we  in  1  store strobe.
- io_wdata  in  WIDTH  store data.
- io_rdata  out  WIDTH  load data, combinational from io_addr.
- in_port  in  N_IN*WIDTH  asynchronous inputs; port i occupies bits [i*WIDTH +: WIDTH].
- out_port  out  N_OUT*WIDTH  registered outputs, packed the same way.
- io_irq  out  1  registered interrupt request, active-high.

## Operation
Register map (word index):
- 0..N_OUT-1: OUT[i], read/write; drives out_port slice i.
- 8..8+N_IN-1: IN[i], read-only; the visible (synchronised) value of port i.
- 14: STATUS, bits [N_IN-1:0]. Bit i is sticky and is set when IN[i] changes. Writing 1 to a bit clears it. Other bits read 0.
- 15: MASK, bits [N_IN-1:0], read/write interrupt enable. Other bits read 0.
- Unmapped indices read 0. Stores to unmapped or read-only indices are ignored.

Input path per port:
- in_port → SYNC_STAGES-flop synchroniser → s[i].
- IN[i] loads s[i] each cycle (debounce filter when enabled).

Change detection:
- On any edge where IN[i] loads a value different from its current value, STATUS[i] is set at that same edge.
- Set and W1C on the same edge for the same bit: the set wins.

Interrupt:
- io_irq is registered as |(STATUS & MASK), computed from the pre-edge values.
- io_irq deasserts one cycle after STATUS is cleared or MASK is cleared.

## Timing
Reset values: all synchroniser flops, IN, OUT, STATUS, MASK, io_irq and debounce counters are 0. out_port is 0.

Latencies:
- Store: the OUT/MASK/STATUS update is visible on out_port and io_rdata after the rising edge on which io_we=1.
- Load: io_rdata reflects register state with zero cycles of latency.
- Input change to IN[i] visible: SYNC_STAGES edges, or SYNC_STAGES+DEB_CYCLES with debounce.
- STATUS set to io_irq: one edge.

Boundary conditions:
- Reset asserted mid-operation clears everything immediately, including a pending interrupt. In-flight synchroniser contents are discarded.
- Non-zero inputs held across reset: IN goes non-zero after release and sets STATUS. Software clears STATUS after boot.
- Store to OUT[i] and a load of the same index in the same cycle: the load returns the old value.
- Inputs changing every cycle without debounce: STATUS stays set. There is no overflow behaviour.

## Configuration
IO_DEBOUNCE_EN:
- Defined: each port has a counter of width clog2(DEB_CYCLES+1).
  - The counter resets to 0 whenever s[i] differs from the previous s[i], otherwise it increments, saturating at DEB_CYCLES.
  - IN[i] loads s[i] only while the counter equals DEB_CYCLES.
  - Glitches shorter than DEB_CYCLES never reach IN or STATUS.
- Undefined: no counters. IN[i] loads s[i] every cycle.

## Test plan
- Reset behaviour: assert resetn=0 mid-run with OUT[0]=0x1234 and io_irq=1 → out_port, io_irq and every readable register are 0 immediately; they remain 0 after release when inputs are 0.
- Output path: store 0xDEADBEEF to index 2 (N_OUT=3) → out_port[95:64]=0xDEADBEEF after the edge. Load index 2 returns it. Store to index 5 → no change, and a load returns 0.
- Input path and latency: in_port0 steps 0→0x00000055 → IN[0] reads 0x55 exactly SYNC_STAGES edges later. STATUS reads 0x1 on that same edge. With MASK=0x1, io_irq=1 one edge later.
- W1C conflict: hold STATUS[1]=1, then write 0x2 to index 14 on the same edge that in_port1 changes again → STATUS[1] stays 1. A later write of 0x2 with no change clears it, and io_irq falls one edge after.
- Debounce (IO_DEBOUNCE_EN, DEB_CYCLES=4): 3-cycle pulse on in_port0 → IN[0] and STATUS unchanged. A level held for 8 cycles → IN[0] updates SYNC_STAGES+4 edges after the step.
